xbus_rx: RTL and testbench

Receiving end of the XBus blocking handshake for the MC core. A remote transmitter offers a word; the local core executing a read of its x-port blocks until that word arrives. Transfers are unbuffered rendezvous: the sender completes only when this block accepts. The block sits between the MC register-file read path and the XBus pin pair. It also supports sleep-until-data (`slx`) without consuming the word.

---
 rtl/mc_pkg.sv | 24 ++
 rtl/sat_clamp.sv | 29 ++
 rtl/xbus_rx.sv | 99 +++++++++
 tb/tb_xbus_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared MC core word type, bounds and XBus receiver state encoding
// Contents:
//   DATA_W, VMAX       word width and symmetric saturation bound
//   word_t             signed machine word
//   WORD_MAX/WORD_MIN  saturation limits as word_t
//   xrx_state_t        xbus_rx FSM states
package mc_pkg;

  localparam int DATA_W = 11;
  localparam int VMAX   = 999;

  typedef logic signed [DATA_W-1:0] word_t;

  localparam word_t WORD_MAX = word_t'(VMAX);
  localparam word_t WORD_MIN = word_t'(-VMAX);

  typedef enum logic [1:0] {
    XRX_IDLE,
    XRX_WAIT,
    XRX_DONE,
    XRX_SLEEP
  } xrx_state_t;

endpackage

// File: rtl/sat_clamp.sv
// rtl/sat_clamp.sv - combinational signed clamp of a word to -VMAX..+VMAX
// Ports:
//   din      in   DATA_W  two's complement word
//   dout     out  DATA_W  din limited to WORD_MIN..WORD_MAX
//   clamped  out  1       din was outside the legal range
module sat_clamp
  import mc_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              clamped
);

  word_t din_s;
  assign din_s = $signed(din);

  always_comb begin
    dout    = din;
    clamped = 1'b0;
    if (din_s > WORD_MAX) begin
      dout    = WORD_MAX;
      clamped = 1'b1;
    end else if (din_s < WORD_MIN) begin
      dout    = WORD_MIN;
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/xbus_rx.sv
// rtl/xbus_rx.sv - XBus rendezvous receiver with blocking read and sleep-until-data
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   xb_valid/data  transmitter offer, held until accepted
//   xb_ready       registered accept strobe, high only in WAIT
//   rd_req         core read request, held until rd_done
//   rd_done        one-cycle pulse, rd_data valid
//   rd_data        last received word after saturation
//   slx_req        core sleeps until a word is offered
//   slx_done       one-cycle pulse, a word is pending on the bus
//   stall          core must hold its request this cycle
//   clamp_flag     sticky: a received word was saturated
//   clamp_clr      clears clamp_flag (a simultaneous set wins)
module xbus_rx
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              xb_valid,
  input  logic [DATA_W-1:0] xb_data,
  output logic              xb_ready,
  input  logic              rd_req,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  input  logic              slx_req,
  output logic              slx_done,
  output logic              stall,
  output logic              clamp_flag,
  input  logic              clamp_clr
);

  xrx_state_t        state_q, state_d;
  logic              slx_fire;
  logic              capture;
  logic [DATA_W-1:0] sat_word;
  logic              sat_hit;

  sat_clamp u_sat (
    .din     (xb_data),
    .dout    (sat_word),
    .clamped (sat_hit)
  );

  // xb_ready is decoded from the state register alone, so the transmitter
  // never sees a combinational path back from its own xb_valid.
  assign xb_ready = (state_q == XRX_WAIT);
  assign rd_done  = (state_q == XRX_DONE);
  // A word offered in WAIT is always taken, even if rd_req drops on that edge.
  assign capture  = xb_ready & xb_valid;
  assign stall    = (rd_req & ~rd_done) | (slx_req & ~slx_done);

  always_comb begin
    state_d  = state_q;
    slx_fire = 1'b0;
    case (state_q)
      XRX_IDLE: begin
        if (rd_req) begin
          state_d = XRX_WAIT;
        end else if (slx_req) begin
          // Word already on the bus: report it without a trip through SLEEP.
          if (xb_valid) slx_fire = 1'b1;
          else          state_d  = XRX_SLEEP;
        end
      end
      XRX_WAIT: begin
        if (xb_valid)     state_d = XRX_DONE;
        else if (!rd_req) state_d = XRX_IDLE;
      end
      XRX_DONE: begin
        state_d = rd_req ? XRX_WAIT : XRX_IDLE;
      end
      XRX_SLEEP: begin
        if (!slx_req) begin
          state_d = XRX_IDLE;
        end else if (xb_valid) begin
          slx_fire = 1'b1;
          state_d  = XRX_IDLE;
        end
      end
      default: state_d = XRX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= XRX_IDLE;
      slx_done   <= 1'b0;
      rd_data    <= '0;
      clamp_flag <= 1'b0;
    end else begin
      state_q  <= state_d;
      slx_done <= slx_fire;
      if (capture) rd_data <= sat_word;
      if (capture && sat_hit) clamp_flag <= 1'b1;
      else if (clamp_clr)     clamp_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xbus_rx.sv
// tb/tb_xbus_rx.sv - scoreboard bench for xbus_rx
module tb_xbus_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        xb_valid;
  logic [10:0] xb_data;
  logic        xb_ready;
  logic        rd_req;
  logic        rd_done;
  logic [10:0] rd_data;
  logic        slx_req;
  logic        slx_done;
  logic        stall;
  logic        clamp_flag;
  logic        clamp_clr;

  xbus_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xb_valid   (xb_valid),
    .xb_data    (xb_data),
    .xb_ready   (xb_ready),
    .rd_req     (rd_req),
    .rd_done    (rd_done),
    .rd_data    (rd_data),
    .slx_req    (slx_req),
    .slx_done   (slx_done),
    .stall      (stall),
    .clamp_flag (clamp_flag),
    .clamp_clr  (clamp_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic signed [10:0] exp_q[$];
  int slx_pending = 0;

  function automatic void chk(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endfunction

  // Monitor: every rd_done pops the next expected word, every slx_done
  // must have been announced by the stimulus.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rd_done) begin
        chk("ready_low_in_done", xb_ready, 0);
        chk("rd_done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic signed [10:0] e;
          e = exp_q.pop_front();
          chk("rd_data", $signed(rd_data), e);
        end
      end
      if (slx_done) begin
        chk("slx_done_expected", slx_pending, 1);
        slx_pending = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rd();
    int n;
    n = 0;
    while (!rd_done && n < 20) begin
      tick();
      n++;
    end
    chk("rd_done_seen", rd_done, 1);
  endtask

  task automatic do_read(input logic signed [10:0] w, input int delay,
                         input logic signed [10:0] e);
    exp_q.push_back(e);
    rd_req = 1'b1;
    repeat (delay) tick();
    xb_valid = 1'b1;
    xb_data  = w;
    wait_rd();
    rd_req   = 1'b0;
    xb_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  word;
    logic exp_done;
    rst_n = 1'b0; xb_valid = 1'b0; xb_data = '0;
    rd_req = 1'b0; slx_req = 1'b0; clamp_clr = 1'b0;
    tick(); tick();
    chk("rst_xb_ready", xb_ready, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_slx_done", slx_done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_clamp", clamp_flag, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    tick();

    // Basic read: rd_req in cycle 0, word 42 offered from cycle 3.
    exp_q.push_back(11'sd42);
    rd_req = 1'b1;
    tick();
    chk("basic_ready_c1", xb_ready, 1);
    tick(); tick();
    chk("basic_no_done_c3", rd_done, 0);
    xb_valid = 1'b1; xb_data = 11'd42;
    tick();
    chk("basic_done_c4", rd_done, 1);
    chk("basic_stall_c4", stall, 0);
    rd_req = 1'b0; xb_valid = 1'b0;
    tick();
    chk("basic_done_c5", rd_done, 0);
    chk("basic_ready_c5", xb_ready, 0);

    // Saturation (bounds chosen inside the 11-bit range).
    do_read(11'sd1023, 1, 11'sd999);
    chk("clamp_hi", clamp_flag, 1);
    do_read(-11'sd1024, 1, -11'sd999);
    chk("clamp_lo", clamp_flag, 1);
    clamp_clr = 1'b1;
    tick();
    clamp_clr = 1'b0;
    chk("clamp_cleared", clamp_flag, 0);
    do_read(11'sd999, 1, 11'sd999);
    chk("clamp_at_max", clamp_flag, 0);
    do_read(-11'sd999, 0, -11'sd999);
    chk("clamp_at_min", clamp_flag, 0);
    // Set and clear on the same edge: set wins.
    exp_q.push_back(11'sd999);
    rd_req = 1'b1;
    tick();
    xb_valid = 1'b1; xb_data = 11'd1000; clamp_clr = 1'b1;
    tick();
    chk("clamp_set_wins", clamp_flag, 1);
    clamp_clr = 1'b0; rd_req = 1'b0; xb_valid = 1'b0;
    tick();

    // Asynchronous reset while WAIT with a word on offer.
    rd_req = 1'b1;
    tick();
    chk("rst_pre_ready", xb_ready, 1);
    #2;
    xb_valid = 1'b1; xb_data = 11'd77; rst_n = 1'b0;
    #1;
    chk("arst_xb_ready", xb_ready, 0);
    chk("arst_rd_done", rd_done, 0);
    chk("arst_slx_done", slx_done, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_clamp", clamp_flag, 0);
    tick(); tick();
    chk("arst_hold_ready", xb_ready, 0);
    rst_n = 1'b1;
    exp_q.push_back(11'sd77);
    wait_rd();
    rd_req = 1'b0; xb_valid = 1'b0;
    repeat (4) tick();
    chk("arst_once", exp_q.size(), 0);

    // Back-to-back stream 1,2,3 with rd_req held.
    exp_q.push_back(11'sd1); exp_q.push_back(11'sd2); exp_q.push_back(11'sd3);
    rd_req = 1'b1; xb_valid = 1'b1; xb_data = 11'd1; word = 1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_done = (i == 2) || (i == 4) || (i == 6);
      chk("b2b_done_cadence", rd_done, exp_done);
      if (rd_done) begin
        word++;
        if (word <= 3) xb_data = 11'(word);
        else begin
          xb_valid = 1'b0;
          rd_req   = 1'b0;
        end
      end
    end

    // Sleep: word 7 offered in cycle 5, slx_done in cycle 6.
    slx_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("slx_wait_done", slx_done, 0);
      chk("slx_wait_ready", xb_ready, 0);
      #1;
      chk("slx_wait_stall", stall, 1);
    end
    xb_valid = 1'b1; xb_data = 11'd7; slx_pending = 1;
    tick();
    chk("slx_done_c6", slx_done, 1);
    chk("slx_stall_c6", stall, 0);
    chk("slx_ready_c6", xb_ready, 0);
    slx_req = 1'b0;
    tick();
    chk("slx_done_c7", slx_done, 0);
    do_read(11'sd7, 0, 11'sd7);

    // Sleep with the word already on offer.
    xb_valid = 1'b1; xb_data = 11'd5; slx_req = 1'b1; slx_pending = 1;
    tick();
    chk("slx_pre_done", slx_done, 1);
    slx_req = 1'b0;
    tick();
    chk("slx_pre_done_off", slx_done, 0);
    do_read(11'sd5, 0, 11'sd5);

    // Sleep abandoned: no pulse.
    slx_req = 1'b1;
    repeat (3) tick();
    slx_req = 1'b0;
    tick(); tick();
    chk("slx_abort_done", slx_done, 0);
    chk("slx_abort_ready", xb_ready, 0);

    // Abort race: rd_req falls on the edge that transfers 13.
    exp_q.push_back(11'sd13);
    rd_req = 1'b1;
    tick();
    xb_valid = 1'b1; xb_data = 11'd13; rd_req = 1'b0;
    tick();
    chk("race_done", rd_done, 1);
    xb_valid = 1'b0;
    tick();

    // Abort with nothing offered.
    rd_req = 1'b1;
    tick();
    chk("abort_ready_on", xb_ready, 1);
    rd_req = 1'b0;
    tick();
    chk("abort_ready_off", xb_ready, 0);
    chk("abort_no_done", rd_done, 0);
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("slx_pending_empty", slx_pending, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
